// File: rtl/nios_fprint_led_pio_if.sv
// Avalon-MM slave bus bundle for the fprint LED output PIO.
// The master drives the request fields; the slave returns registered readdata.
interface nios_fprint_led_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/nios_fprint_led_pio.sv
// Output PIO for the Nios fprint system: software-controlled data register driving
// out_port, plus a one-shot engine that ORs a latched mask onto out_port for N cycles.
module nios_fprint_led_pio #(
   parameter int                 WIDTH       = 8,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   parameter int                 CNT_WIDTH   = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   nios_fprint_led_pio_if.slave  bus,
   output logic [WIDTH-1:0]      out_port,
   output logic                  irq
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_PULSE = 1'b1
   } state_t;

   localparam logic [2:0] A_DATA     = 3'd0;
   localparam logic [2:0] A_MASK     = 3'd1;
   localparam logic [2:0] A_CNT      = 3'd2;
   localparam logic [2:0] A_STATUS   = 3'd3;
   localparam logic [2:0] A_OUTSET   = 3'd4;
   localparam logic [2:0] A_OUTCLEAR = 3'd5;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WIDTH-1:0]       r_data;
   logic [WIDTH-1:0]       r_mask;
   logic [WIDTH-1:0]       r_mask_lat;
   logic [CNT_WIDTH-1:0]   r_count;
   logic                   r_done;
   logic                   r_irq_en;
   logic [31:0]            r_readdata;

   logic                   w_wr;
   logic                   w_wr_cnt;
   logic                   w_wr_sts;
   logic [CNT_WIDTH-1:0]   w_cnt_val;
   logic                   w_cnt_zero;
   logic                   w_busy;
   logic                   w_load;
   logic                   w_abort;
   logic                   w_expire;
   logic [31:0]            w_rdata;
   logic                   w_unused;

   assign w_wr       = bus.chipselect & ~bus.write_n;
   assign w_wr_cnt   = w_wr && (bus.address == A_CNT);
   assign w_wr_sts   = w_wr && (bus.address == A_STATUS);
   assign w_cnt_val  = bus.writedata[CNT_WIDTH-1:0];
   assign w_cnt_zero = (w_cnt_val == '0);
   // Upper writedata bits beyond the register widths are deliberately ignored.
   assign w_unused   = &{1'b0, bus.writedata};

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_wr_cnt && !w_cnt_zero) w_state_nxt = S_PULSE;
         end
         S_PULSE: begin
            if (w_wr_cnt)                w_state_nxt = w_cnt_zero ? S_IDLE : S_PULSE;
            else if (r_count == CNT_ONE) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A PULSE_CNT write on the expiry edge is a restart, so it suppresses done.
   always_comb begin
      w_busy   = (r_state == S_PULSE);
      w_load   = w_wr_cnt && !w_cnt_zero;
      w_abort  = w_busy && w_wr_cnt && w_cnt_zero;
      w_expire = w_busy && !w_wr_cnt && (r_count == CNT_ONE);
      out_port = r_data | (w_busy ? r_mask_lat : '0);
      irq      = r_done & r_irq_en;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count    <= '0;
         r_mask_lat <= '0;
      end else if (w_load) begin
         r_count    <= w_cnt_val;
         r_mask_lat <= r_mask;
      end else if (w_abort) begin
         r_count    <= '0;
      end else if (w_busy) begin
         r_count    <= r_count - CNT_ONE;
      end
   end

   // Expiry outranks a simultaneous STATUS write so a completion is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done   <= 1'b0;
         r_irq_en <= 1'b0;
      end else begin
         if (w_expire)      r_done <= 1'b1;
         else if (w_wr_sts) r_done <= 1'b0;
         if (w_wr_sts)      r_irq_en <= bus.writedata[2];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= RESET_VALUE;
         r_mask <= '0;
      end else if (w_wr) begin
         case (bus.address)
            A_DATA:     r_data <= bus.writedata[WIDTH-1:0];
            A_MASK:     r_mask <= bus.writedata[WIDTH-1:0];
            A_OUTSET:   r_data <= r_data | bus.writedata[WIDTH-1:0];
            A_OUTCLEAR: r_data <= r_data & ~bus.writedata[WIDTH-1:0];
            default:    ;
         endcase
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.address)
         A_DATA:   w_rdata[WIDTH-1:0]     = r_data;
         A_MASK:   w_rdata[WIDTH-1:0]     = r_mask;
         A_CNT:    w_rdata[CNT_WIDTH-1:0] = r_count;
         A_STATUS: w_rdata[2:0]           = {r_irq_en, r_done, w_busy};
         default:  w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_readdata <= '0;
      else       r_readdata <= w_rdata;
   end

   assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_nios_fprint_led_pio.sv
// Self-checking bench for nios_fprint_led_pio: directed scenarios plus randomized
// bus traffic compared against a behavioural model of the register map and pulse.
module tb_nios_fprint_led_pio;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] out_port;
   logic       irq;

   int total = 0;
   int bad   = 0;

   nios_fprint_led_pio_if bus ();

   nios_fprint_led_pio #(
      .WIDTH       (8),
      .RESET_VALUE (8'h00),
      .CNT_WIDTH   (24)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .out_port (out_port),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   // Behavioural model: remaining pulse cycles as a plain integer.
   logic [7:0]  m_data, m_mask, m_lat;
   int          m_count;
   logic        m_done, m_irq_en;
   logic [31:0] m_rd;

   function automatic logic [7:0] exp_out();
      return m_data | ((m_count > 0) ? m_lat : 8'h00);
   endfunction

   function automatic logic exp_irq();
      return m_done & m_irq_en;
   endfunction

   task automatic model_edge(input logic rst, input logic cs, input logic wn,
                             input logic [2:0] a, input logic [31:0] d);
      logic        wr;
      logic        expired;
      int          n;
      logic [31:0] rd;
      if (rst) begin
         m_data = 8'h00; m_mask = 8'h00; m_lat = 8'h00; m_count = 0;
         m_done = 1'b0; m_irq_en = 1'b0; m_rd = 32'h0;
         return;
      end
      case (a)
         3'd0:    rd = {24'h0, m_data};
         3'd1:    rd = {24'h0, m_mask};
         3'd2:    rd = m_count;
         3'd3:    rd = {29'h0, m_irq_en, m_done, (m_count > 0)};
         default: rd = 32'h0;
      endcase
      wr      = cs && !wn;
      n       = int'(d & 32'h00FF_FFFF);
      expired = 1'b0;
      if (wr && a == 3'd2) begin
         if (n != 0) begin
            m_count = n;
            m_lat   = m_mask;
         end else begin
            m_count = 0;
         end
      end else if (m_count > 0) begin
         m_count--;
         expired = (m_count == 0);
      end
      if (expired)                m_done = 1'b1;
      else if (wr && a == 3'd3)   m_done = 1'b0;
      if (wr && a == 3'd3)        m_irq_en = d[2];
      if (wr) begin
         case (a)
            3'd0: m_data = d[7:0];
            3'd1: m_mask = d[7:0];
            3'd4: m_data = m_data | d[7:0];
            3'd5: m_data = m_data & ~d[7:0];
            default: ;
         endcase
      end
      m_rd = rd;
   endtask

   // One clock: inputs driven at negedge, model advanced at the edge, outputs settle by next negedge.
   task automatic tick(input logic rst, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] d);
      reset          = rst;
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.address    = a;
      bus.writedata  = d;
      @(posedge clk);
      model_edge(rst, cs, wn, a, d);
      @(negedge clk);
      reset          = 1'b0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      tick(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic idle(input logic [2:0] a);
      tick(1'b0, 1'b0, 1'b1, a, 32'h0);
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
      total++;
      if (out_port !== 8'h00) begin
         bad++; $display("FAIL reset_out_port got=%h want=00", out_port);
      end
      total++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL reset_irq got=%b want=0", irq);
      end
      for (int a = 0; a < 8; a++) begin
         idle(3'(a));
         total++;
         if (bus.readdata !== 32'h0) begin
            bad++; $display("FAIL reset_read addr=%0d got=%h want=0", a, bus.readdata);
         end
      end
   endtask

   task automatic test_data_regs();
      logic [7:0] want [3];
      want[0] = 8'hA5; want[1] = 8'hAF; want[2] = 8'h2E;
      wr(3'd0, 32'h0000_00A5);
      total++;
      if (out_port !== want[0]) begin
         bad++; $display("FAIL data_write got=%h want=%h", out_port, want[0]);
      end
      wr(3'd4, 32'h0000_000F);
      total++;
      if (out_port !== want[1]) begin
         bad++; $display("FAIL outset got=%h want=%h", out_port, want[1]);
      end
      wr(3'd5, 32'hFFFF_FF81);
      total++;
      if (out_port !== want[2]) begin
         bad++; $display("FAIL outclear got=%h want=%h", out_port, want[2]);
      end
      idle(3'd0);
      total++;
      if (bus.readdata !== 32'h0000_002E) begin
         bad++; $display("FAIL read_data got=%h want=0000002e", bus.readdata);
      end
      idle(3'd4);
      total++;
      if (bus.readdata !== 32'h0) begin
         bad++; $display("FAIL read_outset got=%h want=0", bus.readdata);
      end
   endtask

   task automatic test_pulse();
      int hi = 0;
      wr(3'd0, 32'h0);
      wr(3'd1, 32'h3);
      wr(3'd3, 32'h4);
      wr(3'd2, 32'd5);
      for (int i = 0; i < 20 && out_port === 8'h03; i++) begin
         hi++;
         idle(3'd3);
         total++;
         if (bus.readdata !== m_rd) begin
            bad++; $display("FAIL pulse_status i=%0d got=%h want=%h", i, bus.readdata, m_rd);
         end
      end
      total++;
      if (hi != 5) begin
         bad++; $display("FAIL pulse_len got=%0d want=5", hi);
      end
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL pulse_irq got=%b want=1", irq);
      end
      idle(3'd3);
      total++;
      if (bus.readdata !== 32'h6) begin
         bad++; $display("FAIL pulse_done_read got=%h want=6", bus.readdata);
      end
      wr(3'd3, 32'h4);
      total++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL pulse_irq_clear got=%b want=0", irq);
      end
   endtask

   task automatic test_restart();
      int   hi = 0;
      int   dones = 0;
      logic prev_irq;
      wr(3'd3, 32'h4);
      prev_irq = irq;
      wr(3'd2, 32'd10);
      for (int i = 0; i < 30; i++) begin
         if (out_port === 8'h03) hi++;
         if (irq === 1'b1 && prev_irq !== 1'b1) dones++;
         prev_irq = irq;
         total++;
         if (irq !== exp_irq() || out_port !== exp_out()) begin
            bad++;
            $display("FAIL restart_step i=%0d got=%h/%b want=%h/%b", i, out_port, irq, exp_out(), exp_irq());
         end
         if (i == 2) wr(3'd2, 32'd4);
         else        idle(3'd0);
      end
      total++;
      if (hi != 7) begin
         bad++; $display("FAIL restart_len got=%0d want=7", hi);
      end
      total++;
      if (dones != 1) begin
         bad++; $display("FAIL restart_dones got=%0d want=1", dones);
      end
   endtask

   task automatic test_simultaneous();
      // STATUS write on the expiry edge: done must still be set.
      wr(3'd3, 32'h4);
      wr(3'd2, 32'd3);
      idle(3'd0);
      idle(3'd0);
      wr(3'd3, 32'h4);
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL sim_sts_irq got=%b want=1", irq);
      end
      idle(3'd3);
      total++;
      if (bus.readdata !== 32'h6) begin
         bad++; $display("FAIL sim_sts_read got=%h want=6", bus.readdata);
      end
      // PULSE_CNT restart on the expiry edge: no done.
      wr(3'd3, 32'h4);
      wr(3'd2, 32'd2);
      idle(3'd0);
      wr(3'd2, 32'd3);
      total++;
      if (out_port !== 8'h03 || irq !== 1'b0) begin
         bad++; $display("FAIL sim_restart got=%h/%b want=03/0", out_port, irq);
      end
      idle(3'd0);
      idle(3'd0);
      idle(3'd0);
      total++;
      if (out_port !== 8'h00 || irq !== 1'b1) begin
         bad++; $display("FAIL sim_restart_end got=%h/%b want=00/1", out_port, irq);
      end
      // Abort with N=0, then N=0 in idle (upper bits beyond the counter ignored).
      wr(3'd3, 32'h4);
      wr(3'd2, 32'd6);
      idle(3'd0);
      idle(3'd0);
      wr(3'd2, 32'h0);
      total++;
      if (out_port !== 8'h00) begin
         bad++; $display("FAIL abort_out got=%h want=00", out_port);
      end
      wr(3'd2, 32'hFF00_0000);
      idle(3'd3);
      total++;
      if (bus.readdata !== 32'h4 || irq !== 1'b0) begin
         bad++; $display("FAIL abort_status got=%h/%b want=4/0", bus.readdata, irq);
      end
      idle(3'd2);
      total++;
      if (bus.readdata !== 32'h0) begin
         bad++; $display("FAIL abort_count got=%h want=0", bus.readdata);
      end
   endtask

   task automatic test_reset_mid();
      wr(3'd0, 32'h40);
      wr(3'd2, 32'd8);
      idle(3'd0);
      tick(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
      total++;
      if (out_port !== 8'h00 || irq !== 1'b0) begin
         bad++; $display("FAIL rst_mid_out got=%h/%b want=00/0", out_port, irq);
      end
      for (int i = 0; i < 10; i++) idle(3'd3);
      total++;
      if (bus.readdata !== 32'h0 || irq !== 1'b0 || out_port !== 8'h00) begin
         bad++;
         $display("FAIL rst_mid_after got=%h/%b/%h want=0/0/00", bus.readdata, irq, out_port);
      end
   endtask

   task automatic test_random();
      logic [31:0] r, d;
      logic        rst, cs, wn;
      logic [2:0]  a;
      for (int i = 0; i < 400; i++) begin
         r   = $urandom;
         rst = ($urandom_range(0, 99) == 0);
         cs  = r[0] | r[1];
         wn  = (r[3:2] == 2'b00);
         a   = 3'($urandom_range(0, 7));
         d   = $urandom;
         if (a == 3'd2) d[23:0] = 24'($urandom_range(0, 6));
         tick(rst, cs, wn, a, d);
         total++;
         if (out_port !== exp_out() || irq !== exp_irq() || bus.readdata !== m_rd) begin
            bad++;
            $display("FAIL random i=%0d got out=%h irq=%b rd=%h want out=%h irq=%b rd=%h",
                     i, out_port, irq, bus.readdata, exp_out(), exp_irq(), m_rd);
         end
      end
   endtask

   initial begin
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = 3'd0;
      bus.writedata  = 32'h0;
      @(negedge clk);
      test_reset();
      test_data_regs();
      test_pulse();
      test_restart();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation time limit reached");
   end

endmodule
